// File: rtl/smsdac_seg_core.sv
// Segmented mismatch-shaping DAC encoder: WIDTH-bit code -> WIDTH-1 pairs of 2^k elements.
// Latency 1 clk from accepted sample (ena&&smp_en); no backpressure, outputs hold between samples.
module smsdac_seg_core #(
  parameter int          WIDTH     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             smp_en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-2:0] unit_p,
  output logic [WIDTH-2:0] unit_n,
  output logic             dout_vld,
  output logic             sat
);

  localparam int S = WIDTH - 1;

  logic [S-1:0]     unit_p_q, unit_p_d;
  logic [S-1:0]     unit_n_q, unit_n_d;
  logic [S-1:0]     t_q, t_d, t_eff;
  logic [S-1:0]     two_c, one_c;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [1:0]       mode_q;
  logic             dout_vld_q, sat_q;
  logic             acc, sat_c, mode_chg;
  logic [WIDTH-1:0] r_c;

  assign acc      = ena && smp_en;
  assign sat_c    = &din;
  assign r_c      = sat_c ? (din - WIDTH'(1)) : din;
  assign mode_chg = (mode != mode_q);
  assign t_eff    = mode_chg ? '0 : t_q;
  assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Greedy MSB-first digit extraction; each digit is 0, 1 or 2 units of weight 2^k.
  always_comb begin
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] q;
    res   = r_c;
    q     = '0;
    two_c = '0;
    one_c = '0;
    for (int k = S - 1; k >= 0; k--) begin
      q = res >> k;
      if (q >= WIDTH'(2)) begin
        two_c[k] = 1'b1;
        res      = res - (WIDTH'(2) << k);
      end else if (q[0]) begin
        one_c[k] = 1'b1;
        res      = res - (WIDTH'(1) << k);
      end
    end
  end

  always_comb begin
    unit_p_d = two_c;
    unit_n_d = two_c;
    t_d      = t_eff;
    for (int k = 0; k < S; k++) begin
      if (one_c[k]) begin
        case (mode)
          2'd0: begin
            unit_p_d[k] = 1'b1;
          end
          2'd2: begin
            unit_p_d[k] = ~lfsr_q[k];
            unit_n_d[k] = lfsr_q[k];
          end
          default: begin
            unit_p_d[k] = ~t_eff[k];
            unit_n_d[k] = t_eff[k];
            t_d[k]      = ~t_eff[k];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_p_q   <= '0;
      unit_n_q   <= '0;
      dout_vld_q <= 1'b0;
      sat_q      <= 1'b0;
      t_q        <= '0;
      lfsr_q     <= LFSR_SEED;
      mode_q     <= 2'd0;
    end else begin
      dout_vld_q <= acc;
      if (acc) begin
        unit_p_q <= unit_p_d;
        unit_n_q <= unit_n_d;
        sat_q    <= sat_c;
        t_q      <= t_d;
        lfsr_q   <= lfsr_d;
        mode_q   <= mode;
      end
    end
  end

  assign unit_p   = unit_p_q;
  assign unit_n   = unit_n_q;
  assign dout_vld = dout_vld_q;
  assign sat      = sat_q;

endmodule
